// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, RMW FSM states
// and the default RAM depth.
package mips_mem_pkg;

  localparam int DEPTH_WORDS_DEF = 256;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    RMW_WR
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: extracts and extends a load lane from a RAM word,
// and merges store data into a base word for read-modify-write.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        zext_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdWord_i,
  input  logic [31:0] baseWord_i,
  input  logic [31:0] storeData_i,
  output logic [31:0] loadExt_o,
  output logic [31:0] mergeWord_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    case (offset_i)
      2'd1:    byteLane = rdWord_i[23:16];
      2'd2:    byteLane = rdWord_i[15:8];
      2'd3:    byteLane = rdWord_i[7:0];
      default: byteLane = rdWord_i[31:24];
    endcase
    halfLane = offset_i[1] ? rdWord_i[15:0] : rdWord_i[31:16];

    case (size_i)
      SZ_BYTE: loadExt_o = zext_i ? {24'b0, byteLane} : {{24{byteLane[7]}}, byteLane};
      SZ_HALF: loadExt_o = zext_i ? {16'b0, halfLane} : {{16{halfLane[15]}}, halfLane};
      default: loadExt_o = rdWord_i;
    endcase
  end

  // Store merge: only the addressed lane is replaced, the rest comes from the base word.
  always_comb begin
    mergeWord_o = baseWord_i;
    case (size_i)
      SZ_BYTE: begin
        case (offset_i)
          2'd1:    mergeWord_o[23:16] = storeData_i[7:0];
          2'd2:    mergeWord_o[15:8]  = storeData_i[7:0];
          2'd3:    mergeWord_o[7:0]   = storeData_i[7:0];
          default: mergeWord_o[31:24] = storeData_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset_i[1]) mergeWord_o[15:0]  = storeData_i[15:0];
        else             mergeWord_o[31:16] = storeData_i[15:0];
      end
      default: mergeWord_o = storeData_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: single-cycle loads and word stores, two-cycle
// read-modify-write for sub-word stores, registered load data and fault pulse.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int AW          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic [31:0] addrIn,
  input  logic [31:0] dataIn,
  input  logic [31:0] ramDataIn,
  output logic        ramRead,
  output logic        ramWrite,
  output logic [31:0] ramAddr,
  output logic [31:0] ramDataOut,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        stall,
  output logic        accessFault
);

  mem_state_e  state_q, state_d;
  logic [31:0] holdWord_q, holdWord_d;
  logic [31:0] loadData_q, loadData_d;
  logic        loadValid_q, loadValid_d;
  logic        accessFault_q, accessFault_d;

  logic        rdStrobe, wrStrobe, stallRaw;
  logic        req, fault, misaligned, outOfRange;
  logic [31:0] loadExt, mergeWord;

  assign req        = memRead | memWrite;
  assign misaligned = (memSize == SZ_HALF && addrIn[0]) ||
                      (memSize == SZ_WORD && addrIn[1:0] != 2'b00);
  assign outOfRange = (addrIn[31:AW+2] != '0) ||
                      ({2'b00, addrIn[31:2]} >= 32'(DEPTH_WORDS));
  assign fault      = req && ((memSize == 2'b11) || misaligned || outOfRange ||
                              (memRead && memWrite));

  mem_lane_align u_align (
    .size_i      (memSize),
    .zext_i      (memUnsigned),
    .offset_i    (addrIn[1:0]),
    .rdWord_i    (ramDataIn),
    .baseWord_i  (holdWord_q),
    .storeData_i (dataIn),
    .loadExt_o   (loadExt),
    .mergeWord_o (mergeWord)
  );

  always_comb begin
    state_d       = state_q;
    holdWord_d    = holdWord_q;
    loadData_d    = loadData_q;
    loadValid_d   = 1'b0;
    accessFault_d = 1'b0;
    rdStrobe      = 1'b0;
    wrStrobe      = 1'b0;
    stallRaw      = 1'b0;
    ramDataOut    = dataIn;
    case (state_q)
      IDLE: begin
        if (fault) begin
          accessFault_d = 1'b1;
        end else if (memRead) begin
          rdStrobe    = 1'b1;
          loadValid_d = 1'b1;
          loadData_d  = loadExt;
        end else if (memWrite && memSize == SZ_WORD) begin
          wrStrobe = 1'b1;
        end else if (memWrite) begin
          // Sub-word store: fetch the surrounding word while upstream is held.
          rdStrobe   = 1'b1;
          stallRaw   = 1'b1;
          holdWord_d = ramDataIn;
          state_d    = RMW_WR;
        end
      end
      RMW_WR: begin
        wrStrobe   = 1'b1;
        ramDataOut = mergeWord;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      holdWord_q    <= '0;
      loadData_q    <= '0;
      loadValid_q   <= 1'b0;
      accessFault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      holdWord_q    <= holdWord_d;
      loadData_q    <= loadData_d;
      loadValid_q   <= loadValid_d;
      accessFault_q <= accessFault_d;
    end
  end

  // Strobes are gated by reset so an in-flight RMW write is dropped immediately.
  assign ramRead     = rdStrobe & ~reset;
  assign ramWrite    = wrStrobe & ~reset;
  assign stall       = stallRaw & ~reset;
  assign ramAddr     = {{(32-AW){1'b0}}, addrIn[AW+1:2]};
  assign loadData    = loadData_q;
  assign loadValid   = loadValid_q;
  assign accessFault = accessFault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a transaction-level
// memory model with a per-cycle output comparator.
module tb_mem_access_unit;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite, memUnsigned;
  logic [1:0]  memSize;
  logic [31:0] addrIn, dataIn, ramDataIn;
  logic        ramRead, ramWrite, loadValid, stall, accessFault;
  logic [31:0] ramAddr, ramDataOut, loadData;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH_WORDS(256), .AW(AW)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .memSize(memSize), .memUnsigned(memUnsigned), .addrIn(addrIn), .dataIn(dataIn),
    .ramDataIn(ramDataIn), .ramRead(ramRead), .ramWrite(ramWrite), .ramAddr(ramAddr),
    .ramDataOut(ramDataOut), .loadData(loadData), .loadValid(loadValid),
    .stall(stall), .accessFault(accessFault)
  );

  // Physical RAM: written only through the DUT strobes or the preload port.
  logic [31:0] ram [0:255];
  logic [31:0] model_mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;

  assign ramDataIn = ram[ramAddr[AW-1:0]];
  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (ramWrite) ram[ramAddr[AW-1:0]] <= ramDataOut;
  end

  int checks = 0;
  int errors = 0;
  int stall_seen = 0;
  bit chk_en = 1'b0;

  logic        e_rr, e_rw, e_st, e_lv, n_lv, e_af, n_af;
  logic [31:0] e_ld, n_ld, e_do, e_ra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ramRead",     32'(ramRead),     32'(e_rr));
      chk("ramWrite",    32'(ramWrite),    32'(e_rw));
      chk("stall",       32'(stall),       32'(e_st));
      chk("loadValid",   32'(loadValid),   32'(e_lv));
      chk("loadData",    loadData,         e_ld);
      chk("accessFault", 32'(accessFault), 32'(e_af));
      if (e_rr || e_rw) chk("ramAddr", ramAddr, e_ra);
      if (e_rw) chk("ramDataOut", ramDataOut, e_do);
      if (stall) stall_seen++;
    end
  end

  function automatic logic is_fault(input logic rd, input logic wr, input logic [1:0] sz,
                                    input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (rd && wr) return 1'b1;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return a >= 32'd1024;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
    logic [31:0] w, v;
    int sh;
    w = model_mem[a[9:2]];
    if (sz == 2'd0) begin
      sh = (3 - int'(a[1:0])) * 8;
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      sh = (2 - int'(a[1:0])) * 8;
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [1:0] sz, input logic [31:0] a,
                                              input logic [31:0] d, input logic [31:0] old);
    logic [31:0] mask;
    int sh;
    sh   = (sz == 2'd0) ? (3 - int'(a[1:0])) * 8 : (2 - int'(a[1:0])) * 8;
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    e_lv = n_lv; e_ld = n_ld; e_af = n_af;
    n_lv = 1'b0; n_af = 1'b0; n_ld = e_ld;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] d);
    memRead = rd; memWrite = wr; memSize = sz; memUnsigned = uns; addrIn = a; dataIn = d;
    e_rr = 1'b0; e_rw = 1'b0; e_st = 1'b0;
    e_ra = {22'b0, a[9:2]};
    if (is_fault(rd, wr, sz, a)) begin
      n_af = 1'b1;
      cycle();
    end else if (rd) begin
      e_rr = 1'b1; n_lv = 1'b1; n_ld = model_load(sz, uns, a);
      cycle();
    end else if (wr && sz == 2'd2) begin
      e_rw = 1'b1; e_do = d; model_mem[a[9:2]] = d;
      cycle();
    end else if (wr) begin
      e_rr = 1'b1; e_st = 1'b1;
      cycle();
      e_rr = 1'b0; e_st = 1'b0; e_rw = 1'b1;
      e_do = model_merge(sz, a, d, model_mem[a[9:2]]);
      model_mem[a[9:2]] = e_do;
      cycle();
    end else begin
      cycle();
    end
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [31:0] w;
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; memSize = 2'd0; memUnsigned = 1'b0;
    addrIn = '0; dataIn = '0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    e_rr = 0; e_rw = 0; e_st = 0; e_lv = 0; n_lv = 0; e_af = 0; n_af = 0;
    e_ld = '0; n_ld = '0; e_do = '0; e_ra = '0;
    chk_en = 1'b1;

    // Preload RAM under reset; reset-state outputs are checked every cycle here.
    for (int i = 0; i < 256; i++) begin
      case (i)
        4:       w = 32'h8899AABB;
        8:       w = 32'h11223344;
        12:      w = 32'h0BADF00D;
        default: w = $urandom;
      endcase
      model_mem[i] = w;
      @(posedge clk); #1;
      pre_we = 1'b1; pre_a = 8'(i); pre_d = w;
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
    reset = 1'b0;

    // Directed loads on the preset word.
    req(1, 0, 2'd0, 0, 32'h10, 0); chk("lb_0x10", loadData, 32'hFFFFFF88);
    req(1, 0, 2'd0, 1, 32'h13, 0); chk("lbu_0x13", loadData, 32'h000000BB);
    req(1, 0, 2'd1, 0, 32'h12, 0); chk("lh_0x12", loadData, 32'hFFFFAABB);

    // Sub-word stores and a word store.
    req(0, 1, 2'd0, 0, 32'h11, 32'h12345677);
    chk("sb_ram", ram[4], 32'h8877AABB);
    req(1, 0, 2'd2, 0, 32'h10, 0); chk("lw_after_sb", loadData, 32'h8877AABB);
    req(0, 1, 2'd1, 0, 32'h20, 32'h0000CAFE);
    chk("sh_ram", ram[8], 32'hCAFE3344);
    req(0, 1, 2'd2, 0, 32'h20, 32'hDEADBEEF);
    chk("sw_ram", ram[8], 32'hDEADBEEF);

    // Faults.
    req(1, 0, 2'd2, 0, 32'h22, 0);
    chk("fault_misalign", 32'(accessFault), 32'd1);
    chk("fault_keeps_load", loadData, 32'h8877AABB);
    req(1, 0, 2'd2, 0, 32'h400, 0);
    chk("fault_range", 32'(accessFault), 32'd1);
    req(1, 1, 2'd2, 0, 32'h10, 0);
    chk("fault_rdwr", 32'(accessFault), 32'd1);
    idle();

    // Reset asserted while the RMW write is pending.
    memRead = 0; memWrite = 1; memSize = 2'd0; memUnsigned = 0; addrIn = 32'h31; dataIn = 32'hA5;
    e_rr = 1; e_rw = 0; e_st = 1; e_ra = 32'd12;
    cycle();
    reset = 1'b1;
    e_rr = 0; e_rw = 0; e_st = 0;
    e_ld = '0; n_ld = '0; e_lv = 0; n_lv = 0; e_af = 0; n_af = 0;
    cycle();
    memWrite = 0;
    reset = 1'b0;
    chk("rst_rmw_word", ram[12], 32'h0BADF00D);
    req(1, 0, 2'd2, 0, 32'h30, 0); chk("rst_rmw_lw", loadData, 32'h0BADF00D);
    idle();

    // Back-to-back mix with a single stall.
    s0 = stall_seen;
    req(0, 1, 2'd0, 0, 32'h40, 32'h0000005A);
    req(1, 0, 2'd0, 0, 32'h40, 0); chk("b2b_lb", loadData, 32'h0000005A);
    req(0, 1, 2'd2, 0, 32'h44, 32'hF00D8001);
    req(1, 0, 2'd1, 1, 32'h46, 0); chk("b2b_lhu", loadData, 32'h00008001);
    idle();
    chk("b2b_stalls", 32'(stall_seen - s0), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic rd, wr, uns;
      logic [1:0] sz;
      logic [31:0] a, d;
      int k;
      k  = $urandom_range(0, 19);
      rd = (k < 8) || (k == 19);
      wr = (k >= 8 && k < 17) || (k == 19);
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'd1) a = a & ~32'h1;
        if (sz == 2'd2) a = a & ~32'h3;
      end
      if ($urandom_range(0, 15) == 0) a = a | (32'h400 << $urandom_range(0, 21));
      d  = $urandom;
      req(rd, wr, sz, uns, a, d);
    end
    idle();

    for (int i = 0; i < 256; i++) chk("final_ram", ram[i], model_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage access unit sitting between the EX/MEM pipeline register and the word-addressed data RAM. Converts byte addresses and MIPS32 access sizes (lb/lbu/lh/lhu/lw/sb/sh/sw) into word-wide RAM reads and writes. Performs sub-word stores as a stalled read-modify-write, and returns aligned, sign- or zero-extended load data registered for the MEM/WB boundary.

## Interface
- DEPTH_WORDS, 256: RAM depth in 32-bit words.
- AW, 8: word-index width, log2(DEPTH_WORDS).
- clk  in  1  rising-edge clock; one clock domain.
- reset  in  1  asynchronous, active-high.
- memRead  in  1  load request from EX/MEM.
- memWrite  in  1  store request from EX/MEM.
- memSize  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- memUnsigned  in  1  zero-extend loads (lbu/lhu) when 1.
- addrIn  in  32  byte address.
- dataIn  in  32  store data (rt), right-justified.
- ramDataIn  in  32  combinational read data from RAM.
- ramRead  out  1  RAM read enable.
- ramWrite  out  1  RAM write enable.
- ramAddr  out  32  word index {zeros, addrIn[AW+1:2]}.
- ramDataOut  out  32  word written to RAM.
- loadData  out  32  extended load result, registered.
- loadValid  out  1  one-cycle pulse, loadData updated.
- stall  out  1  freeze IF/ID/EX and EX/MEM while 1.
- accessFault  out  1  one-cycle registered pulse for a rejected request.

## Operation
- Big-endian lanes: byte offset 0 = bits 31:24, offset 3 = bits 7:0; half offset 0 = bits 31:16.
- Fault conditions, any of:
  - memSize=11.
  - Half with addrIn[0]=1.
  - Word with addrIn[1:0]≠0.
  - addrIn[31:AW+2]≠0.
  - memRead and memWrite both 1.
- On a fault: no ramRead/ramWrite; accessFault=1 next cycle; loadData and loadValid unchanged.
- Loads, single cycle:
  - ramRead=1 in the request cycle.
  - The selected lane of ramDataIn is extended (sign unless memUnsigned) and registered into loadData, with loadValid=1 the following cycle.
  - stall=0.
- Word store: ramWrite=1, ramDataOut=dataIn in the request cycle. stall=0.
- Sub-word store, FSM IDLE → RMW_WR → IDLE:
  - IDLE, request seen: ramRead=1, stall=1; ramDataIn captured into holdWord; upstream keeps inputs stable.
  - RMW_WR: ramWrite=1, ramDataOut=holdWord with the target lane replaced by dataIn[7:0] or dataIn[15:0]; stall=0; next state IDLE.
- No request: all RAM strobes 0, state stays IDLE.
- ramRead and ramWrite are never 1 in the same cycle.

## Timing
- Reset values:
  - State IDLE.
  - loadData=0, loadValid=0, accessFault=0, holdWord=0.
  - ramRead, ramWrite and stall forced 0 while reset=1.
- Load latency: request in cycle N, loadData valid at the edge ending N, seen as loadValid=1 in N+1.
- Sub-word store: exactly one stall cycle. RAM written in cycle N+1; pipeline advances at the end of N+1.
- Back-to-back requests: no extra bubbles. A request arriving in the cycle after RMW_WR is handled normally.
- Reset asserted in RMW_WR: write aborted (no ramWrite), state IDLE; memory keeps its old word.
- Inputs changing while stall=1 is a protocol violation and is not required to be handled.

## Structure
- Package mips_mem_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum {IDLE, RMW_WR}.
  - DEPTH_WORDS default.
- Sub-module mem_lane_align: purely combinational. Lane select plus extension for loads; lane merge for stores. Instantiated once, shared by both paths.
- Top level contains the FSM, holdWord, fault decode and output registers.

## Test plan
- Word at index 4 preset 0x8899AABB:
  - lb addrIn=0x10 → loadData=0xFFFFFF88, loadValid pulse.
  - lbu addrIn=0x13 → 0x000000BB.
  - lh addrIn=0x12 → 0xFFFFAABB.
- sb addrIn=0x11, dataIn=0x12345677, word 0x8899AABB:
  - stall=1 for one cycle.
  - ramWrite in the next cycle with ramDataOut=0x8877AABB.
  - A following lw 0x10 returns 0x8877AABB.
- sh addrIn=0x20, dataIn=0x0000CAFE onto 0x11223344 → RAM word index 8 = 0xCAFE3344; then sw 0x20, 0xDEADBEEF → written with no stall.
- Fault checks:
  - lw addrIn=0x22 → accessFault pulse, no RAM strobes, loadData unchanged.
  - addrIn=0x400 → accessFault.
  - memRead=memWrite=1 → accessFault.
- Reset asserted during RMW_WR of sb 0x31 → no ramWrite, all outputs at reset values, word index 12 unchanged.
- Back-to-back sb 0x40, lb 0x40, sw 0x44, lhu 0x46 → one stall cycle total; lb returns the just-stored byte.
